// File: rtl/i2c_master_pkg.sv
// Shared I2C master definitions: transaction sequencer states, completion
// status codes and the transfer command codes driven by every stage controller.
package i2c_master_pkg;

  typedef enum logic [2:0] {
    SEQ_IDLE = 3'd0,
    SEQ_ADDR = 3'd1,
    SEQ_LOAD = 3'd2,
    SEQ_BYTE = 3'd3,
    SEQ_GAP  = 3'd4,
    SEQ_STOP = 3'd5,
    SEQ_DONE = 3'd6
  } seq_state_t;

  localparam logic [1:0] SEQ_ST_OK        = 2'd0;
  localparam logic [1:0] SEQ_ST_NACK_ADDR = 2'd1;
  localparam logic [1:0] SEQ_ST_NACK_DATA = 2'd2;
  localparam logic [1:0] SEQ_ST_TIMEOUT   = 2'd3;

  // Codes on the shared 4-tap transfer command bus.
  localparam logic [1:0] TRAS_CMD_START = 2'd0;
  localparam logic [1:0] TRAS_CMD_WRITE = 2'd1;
  localparam logic [1:0] TRAS_CMD_READ  = 2'd2;
  localparam logic [1:0] TRAS_CMD_STOP  = 2'd3;

endpackage

// File: rtl/i2c_trans_sequencer.sv
// Sequences one I2C transaction through the address, data byte and stop stage
// controllers, granting exactly one stage its exec level at a time.
module i2c_trans_sequencer
  import i2c_master_pkg::*;
#(
  parameter int ALEN      = 7,
  parameter int MAX_BYTES = 16,
  parameter int LW        = $clog2(MAX_BYTES + 1)
) (
  input  logic            clock,
  input  logic            rst,
  input  logic            req_vld,
  output logic            req_ready,
  input  logic [ALEN-1:0] req_addr,
  input  logic            req_rd,
  input  logic [LW-1:0]   req_len,
  input  logic [7:0]      wr_data,
  input  logic            wr_data_vld,
  output logic            wr_data_ready,
  output logic [7:0]      rd_data,
  output logic            rd_data_vld,
  output logic            done,
  output logic [1:0]      status,
  output logic            exec_addr,
  output logic [ALEN:0]   addr_word,
  input  logic            exec_addr_finish,
  input  logic            addr_ack,
  input  logic            addr_timeout,
  output logic            exec_byte,
  output logic            byte_rd,
  output logic            byte_last,
  output logic [7:0]      byte_wdata,
  input  logic            exec_byte_finish,
  input  logic [7:0]      byte_rdata,
  input  logic            byte_ack,
  input  logic            byte_timeout,
  output logic            exec_stop,
  input  logic            exec_stop_finish
);

  localparam logic [LW-1:0] MAX_LEN = LW'(MAX_BYTES);

  seq_state_t    state_r;
  logic          rd_r;
  logic [LW-1:0] len_r;
  logic [LW-1:0] byte_cnt_r;
  logic          last_s;

  // Flags the byte currently being sequenced as the final one of the transaction.
  always_comb begin
    last_s = (byte_cnt_r == (len_r - LW'(1)));
  end

  // Transaction state machine; every output is a register updated here.
  // Stage exec levels rise one cycle after their state is entered (the ADDR
  // grant is issued together with the accept) so consecutive grants are
  // always separated by a cycle with every exec low.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_r       <= SEQ_IDLE;
      rd_r          <= 1'b0;
      len_r         <= '0;
      byte_cnt_r    <= '0;
      req_ready     <= 1'b0;
      wr_data_ready <= 1'b0;
      rd_data       <= 8'h00;
      rd_data_vld   <= 1'b0;
      done          <= 1'b0;
      status        <= SEQ_ST_OK;
      exec_addr     <= 1'b0;
      addr_word     <= '0;
      exec_byte     <= 1'b0;
      byte_rd       <= 1'b0;
      byte_last     <= 1'b0;
      byte_wdata    <= 8'h00;
      exec_stop     <= 1'b0;
    end else begin
      rd_data_vld <= 1'b0;
      done        <= 1'b0;
      case (state_r)
        SEQ_IDLE: begin
          if (req_vld && req_ready) begin
            req_ready  <= 1'b0;
            addr_word  <= {req_addr, req_rd};
            rd_r       <= req_rd;
            len_r      <= (req_len > MAX_LEN) ? MAX_LEN : req_len;
            byte_cnt_r <= '0;
            status     <= SEQ_ST_OK;
            exec_addr  <= 1'b1;
            state_r    <= SEQ_ADDR;
          end else begin
            req_ready <= 1'b1;
          end
        end
        SEQ_ADDR: begin
          if (exec_addr && exec_addr_finish) begin
            exec_addr <= 1'b0;
            if (addr_timeout) begin
              status  <= SEQ_ST_TIMEOUT;
              state_r <= SEQ_STOP;
            end else if (!addr_ack) begin
              status  <= SEQ_ST_NACK_ADDR;
              state_r <= SEQ_STOP;
            end else if (len_r == '0) begin
              state_r <= SEQ_STOP;
            end else if (rd_r) begin
              state_r <= SEQ_BYTE;
            end else begin
              state_r <= SEQ_LOAD;
            end
          end else begin
            exec_addr <= 1'b1;
          end
        end
        SEQ_LOAD: begin
          if (wr_data_ready && wr_data_vld) begin
            wr_data_ready <= 1'b0;
            byte_wdata    <= wr_data;
            state_r       <= SEQ_BYTE;
          end else begin
            wr_data_ready <= 1'b1;
          end
        end
        SEQ_BYTE: begin
          if (exec_byte && exec_byte_finish) begin
            exec_byte <= 1'b0;
            byte_rd   <= 1'b0;
            byte_last <= 1'b0;
            if (byte_timeout) begin
              status  <= SEQ_ST_TIMEOUT;
              state_r <= SEQ_STOP;
            end else if (!rd_r && !byte_ack) begin
              status  <= SEQ_ST_NACK_DATA;
              state_r <= SEQ_STOP;
            end else begin
              if (rd_r) begin
                rd_data     <= byte_rdata;
                rd_data_vld <= 1'b1;
              end
              byte_cnt_r <= byte_cnt_r + LW'(1);
              state_r    <= last_s ? SEQ_STOP : SEQ_GAP;
            end
          end else begin
            exec_byte <= 1'b1;
            byte_rd   <= rd_r;
            byte_last <= last_s;
          end
        end
        // Lets the byte stage see exec fall and clear its counters between bytes.
        SEQ_GAP: begin
          state_r <= rd_r ? SEQ_BYTE : SEQ_LOAD;
        end
        SEQ_STOP: begin
          if (exec_stop && exec_stop_finish) begin
            exec_stop <= 1'b0;
            state_r   <= SEQ_DONE;
          end else begin
            exec_stop <= 1'b1;
          end
        end
        SEQ_DONE: begin
          done    <= 1'b1;
          state_r <= SEQ_IDLE;
        end
        default: begin
          exec_addr     <= 1'b0;
          exec_byte     <= 1'b0;
          exec_stop     <= 1'b0;
          wr_data_ready <= 1'b0;
          state_r       <= SEQ_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_trans_sequencer.sv
// Directed bench for i2c_trans_sequencer: stage responders, a transaction-level
// expectation model, a per-cycle compare process and literal pins per scenario.
module tb_i2c_trans_sequencer;

  logic       clock, rst;
  logic       req_vld, req_ready;
  logic [6:0] req_addr;
  logic       req_rd;
  logic [4:0] req_len;
  logic [7:0] wr_data;
  logic       wr_data_vld, wr_data_ready;
  logic [7:0] rd_data;
  logic       rd_data_vld, done;
  logic [1:0] status;
  logic       exec_addr;
  logic [7:0] addr_word;
  logic       exec_addr_finish, addr_ack, addr_timeout;
  logic       exec_byte, byte_rd, byte_last;
  logic [7:0] byte_wdata;
  logic       exec_byte_finish;
  logic [7:0] byte_rdata;
  logic       byte_ack, byte_timeout;
  logic       exec_stop, exec_stop_finish;

  i2c_trans_sequencer dut (
    .clock(clock), .rst(rst),
    .req_vld(req_vld), .req_ready(req_ready), .req_addr(req_addr),
    .req_rd(req_rd), .req_len(req_len),
    .wr_data(wr_data), .wr_data_vld(wr_data_vld), .wr_data_ready(wr_data_ready),
    .rd_data(rd_data), .rd_data_vld(rd_data_vld),
    .done(done), .status(status),
    .exec_addr(exec_addr), .addr_word(addr_word),
    .exec_addr_finish(exec_addr_finish), .addr_ack(addr_ack), .addr_timeout(addr_timeout),
    .exec_byte(exec_byte), .byte_rd(byte_rd), .byte_last(byte_last),
    .byte_wdata(byte_wdata), .exec_byte_finish(exec_byte_finish),
    .byte_rdata(byte_rdata), .byte_ack(byte_ack), .byte_timeout(byte_timeout),
    .exec_stop(exec_stop), .exec_stop_finish(exec_stop_finish)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
    end
  endtask

  // Scenario configuration (written by the main sequence only).
  logic [7:0] cfg_wb [0:15];
  logic [7:0] cfg_rb [0:15];
  logic       cfg_aack, cfg_ato;
  int         cfg_nack, cfg_to, lat_g;

  // Expected transaction outcome (written by the main sequence only).
  logic [7:0] exp_word;
  logic       exp_rdflag;
  logic [1:0] exp_status;
  int         exp_nwin, exp_nrd, exp_hs;
  logic       exp_last [0:15];
  logic [7:0] exp_wd [0:15];
  logic [7:0] exp_rd [0:15];

  // Observations (written by the compare process only).
  logic [7:0] obs_word;
  logic [15:0] obs_lastmask;
  logic [7:0] obs_wd [$];
  logic [7:0] obs_rd [$];
  int obs_stops, win_idx, rd_idx, done_cnt;

  // Responder-owned counters.
  int a_cnt, b_cnt, s_cnt, bidx, widx;
  int started;

  // Stage controllers and write-data source.
  initial begin
    exec_addr_finish = 1'b0; addr_ack = 1'b0; addr_timeout = 1'b0;
    exec_byte_finish = 1'b0; byte_rdata = 8'hEE; byte_ack = 1'b0; byte_timeout = 1'b0;
    exec_stop_finish = 1'b0; wr_data = 8'h00; wr_data_vld = 1'b0;
    a_cnt = 0; b_cnt = 0; s_cnt = 0; bidx = 0; widx = 0;
    forever begin
      @(negedge clock);
      if (rst) begin
        a_cnt = 0; b_cnt = 0; s_cnt = 0; bidx = 0; widx = 0;
        exec_addr_finish = 1'b0; exec_byte_finish = 1'b0; exec_stop_finish = 1'b0;
        byte_timeout = 1'b0; wr_data_vld = 1'b0;
      end else begin
        if (exec_addr) begin
          bidx = 0; widx = 0;
        end
        if (exec_addr && a_cnt == lat_g) begin
          exec_addr_finish = 1'b1; addr_ack = cfg_aack; addr_timeout = cfg_ato;
          a_cnt++;
        end else begin
          exec_addr_finish = 1'b0; addr_ack = 1'b0; addr_timeout = 1'b0;
          a_cnt = exec_addr ? a_cnt + 1 : 0;
        end
        if (exec_byte && b_cnt == lat_g && bidx < 16) begin
          exec_byte_finish = 1'b1;
          byte_rdata   = cfg_rb[bidx];
          byte_ack     = (cfg_nack != bidx);
          byte_timeout = (cfg_to == bidx);
          bidx++;
          b_cnt++;
        end else begin
          exec_byte_finish = 1'b0; byte_rdata = 8'hEE; byte_ack = 1'b0; byte_timeout = 1'b0;
          b_cnt = exec_byte ? b_cnt + 1 : 0;
        end
        if (exec_stop && s_cnt == lat_g) begin
          exec_stop_finish = 1'b1;
          s_cnt++;
        end else begin
          exec_stop_finish = 1'b0;
          s_cnt = exec_stop ? s_cnt + 1 : 0;
        end
        if (wr_data_ready && widx < 16) begin
          wr_data_vld = 1'b1;
          wr_data = cfg_wb[widx];
          widx++;
        end else begin
          wr_data_vld = 1'b0;
        end
      end
    end
  end

  // Per-cycle compare against the expectation model.
  initial begin
    logic [2:0] prev_ex, cur_ex;
    prev_ex = 3'b000;
    obs_word = 8'h00; obs_lastmask = 16'h0000; obs_stops = 0;
    win_idx = 0; rd_idx = 0; done_cnt = 0;
    forever begin
      @(negedge clock);
      if (rst) begin
        prev_ex = 3'b000;
      end else begin
        cur_ex = {exec_addr, exec_byte, exec_stop};
        chk("exec_onehot", 32'($onehot0(cur_ex)), 32'd1);
        if ((cur_ex & ~prev_ex) != 3'b000)
          chk("exec_gap", 32'(prev_ex), 32'd0);
        if (cur_ex != 3'b000 || done)
          chk("req_ready_busy", 32'(req_ready), 32'd0);
        if (exec_addr && !prev_ex[2]) begin
          chk("addr_txn_active", 32'(started != done_cnt), 32'd1);
          obs_word = addr_word; obs_lastmask = 16'h0000; obs_stops = 0;
          win_idx = 0; rd_idx = 0;
          obs_wd.delete(); obs_rd.delete();
          chk("addr_word", 32'(addr_word), 32'(exp_word));
        end
        if (exec_byte && !prev_ex[1]) begin
          chk("byte_window_expected", 32'(win_idx < exp_nwin), 32'd1);
          if (win_idx < exp_nwin) begin
            chk("byte_rd", 32'(byte_rd), 32'(exp_rdflag));
            chk("byte_last", 32'(byte_last), 32'(exp_last[win_idx]));
            if (!exp_rdflag) chk("byte_wdata", 32'(byte_wdata), 32'(exp_wd[win_idx]));
            obs_lastmask[win_idx] = byte_last;
            obs_wd.push_back(byte_wdata);
          end
          win_idx++;
        end
        if (rd_data_vld) begin
          chk("rd_pulse_expected", 32'(rd_idx < exp_nrd), 32'd1);
          if (rd_idx < exp_nrd) chk("rd_data", 32'(rd_data), 32'(exp_rd[rd_idx]));
          obs_rd.push_back(rd_data);
          rd_idx++;
        end
        if (exec_stop && !prev_ex[0]) obs_stops++;
        if (done) begin
          chk("done_expected", 32'(started != done_cnt), 32'd1);
          chk("status", 32'(status), 32'(exp_status));
          chk("byte_windows", 32'(win_idx), 32'(exp_nwin));
          chk("rd_pulses", 32'(rd_idx), 32'(exp_nrd));
          chk("stop_count", 32'(obs_stops), 32'd1);
          chk("wr_handshakes", 32'(widx), 32'(exp_hs));
          done_cnt++;
        end
        prev_ex = cur_ex;
      end
    end
  end

  // Builds the expected outcome from the transaction rules, then issues the request.
  task automatic start_txn(input logic [6:0] addr, input logic rd, input logic [4:0] len,
                           input logic aack, input logic ato, input int nack, input int to);
    int eff;
    bit acc;
    cfg_aack = aack; cfg_ato = ato; cfg_nack = nack; cfg_to = to;
    eff = (int'(len) > 16) ? 16 : int'(len);
    exp_word = {addr, rd}; exp_rdflag = rd; exp_nwin = 0; exp_nrd = 0;
    if (ato) exp_status = 2'd3;
    else if (!aack) exp_status = 2'd1;
    else begin
      exp_status = 2'd0;
      for (int i = 0; i < eff; i++) begin
        exp_last[i] = (i == eff - 1);
        exp_wd[i] = cfg_wb[i];
        exp_nwin = i + 1;
        if (to == i) begin exp_status = 2'd3; break; end
        if (!rd && nack == i) begin exp_status = 2'd2; break; end
        if (rd) begin exp_rd[exp_nrd] = cfg_rb[i]; exp_nrd++; end
      end
    end
    exp_hs = rd ? 0 : exp_nwin;
    started++;
    @(negedge clock);
    req_addr = addr; req_rd = rd; req_len = len; req_vld = 1'b1;
    acc = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (req_ready) begin acc = 1'b1; break; end
      @(negedge clock);
    end
    chk("req_accepted", 32'(acc), 32'd1);
    @(negedge clock);
    req_vld = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 3000; i++) begin
      if (done_cnt == started) break;
      @(negedge clock);
    end
    chk("txn_complete", 32'(done_cnt == started), 32'd1);
    repeat (2) @(negedge clock);
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_ctl"}, 32'({req_ready, wr_data_ready, rd_data_vld, done, status,
                           exec_addr, exec_byte, exec_stop, byte_rd, byte_last}), 32'd0);
    chk({nm, "_data"}, 32'({addr_word, byte_wdata, rd_data}), 32'd0);
  endtask

  initial begin
    bit seen;
    rst = 1'b1; req_vld = 1'b0; req_addr = 7'h00; req_rd = 1'b0; req_len = 5'd0;
    cfg_aack = 1'b1; cfg_ato = 1'b0; cfg_nack = -1; cfg_to = -1; lat_g = 1;
    started = 0;
    for (int i = 0; i < 16; i++) begin cfg_wb[i] = 8'h00; cfg_rb[i] = 8'h00; end
    exp_word = 8'h00; exp_rdflag = 1'b0; exp_status = 2'd0;
    exp_nwin = 0; exp_nrd = 0; exp_hs = 0;
    #1 chk_all_zero("reset");
    repeat (3) @(negedge clock);
    rst = 1'b0;
    @(negedge clock);
    chk("req_ready_after_reset", 32'(req_ready), 32'd1);

    // Write 2 bytes
    lat_g = 1; cfg_wb[0] = 8'hA5; cfg_wb[1] = 8'h3C;
    start_txn(7'h50, 1'b0, 5'd2, 1'b1, 1'b0, -1, -1); wait_done();
    chk("w2_word", 32'(obs_word), 32'h0000_00A0);
    chk("w2_last", 32'(obs_lastmask), 32'h0000_0002);
    chk("w2_nwd", 32'(obs_wd.size()), 32'd2);
    if (obs_wd.size() == 2) begin
      chk("w2_wd0", 32'(obs_wd[0]), 32'h0000_00A5);
      chk("w2_wd1", 32'(obs_wd[1]), 32'h0000_003C);
    end
    chk("w2_status", 32'(status), 32'd0);

    // Read 3 bytes
    lat_g = 0; cfg_rb[0] = 8'h11; cfg_rb[1] = 8'h22; cfg_rb[2] = 8'h33;
    start_txn(7'h1A, 1'b1, 5'd3, 1'b1, 1'b0, -1, -1); wait_done();
    chk("r3_word", 32'(obs_word), 32'h0000_0035);
    chk("r3_last", 32'(obs_lastmask), 32'h0000_0004);
    chk("r3_nrd", 32'(obs_rd.size()), 32'd3);
    if (obs_rd.size() == 3)
      chk("r3_rd", 32'({obs_rd[0], obs_rd[1], obs_rd[2]}), 32'h0011_2233);
    chk("r3_status", 32'(status), 32'd0);

    // Address NACK
    lat_g = 2;
    start_txn(7'h22, 1'b0, 5'd2, 1'b0, 1'b0, -1, -1); wait_done();
    chk("an_windows", 32'(win_idx), 32'd0);
    chk("an_stops", 32'(obs_stops), 32'd1);
    chk("an_status", 32'(status), 32'd1);

    // Data NACK on byte 1 of 4
    lat_g = 1;
    for (int i = 0; i < 4; i++) cfg_wb[i] = 8'(i + 1);
    start_txn(7'h2B, 1'b0, 5'd4, 1'b1, 1'b0, 1, -1); wait_done();
    chk("dn_windows", 32'(win_idx), 32'd2);
    chk("dn_wr_hs", 32'(widx), 32'd2);
    repeat (3) @(negedge clock);
    chk("dn_status_held", 32'(status), 32'd2);

    // Finish and timeout together on the first read byte
    cfg_rb[0] = 8'h77;
    start_txn(7'h33, 1'b1, 5'd2, 1'b1, 1'b0, -1, 0); wait_done();
    chk("to_nrd", 32'(obs_rd.size()), 32'd0);
    chk("to_status", 32'(status), 32'd3);

    // Address-only probe
    start_txn(7'h44, 1'b0, 5'd0, 1'b1, 1'b0, -1, -1); wait_done();
    chk("probe_windows", 32'(win_idx), 32'd0);
    chk("probe_stops", 32'(obs_stops), 32'd1);
    chk("probe_status", 32'(status), 32'd0);

    // Address timeout outranks the ack
    start_txn(7'h45, 1'b1, 5'd1, 1'b1, 1'b1, -1, -1); wait_done();
    chk("ato_status", 32'(status), 32'd3);

    // Length above the maximum is clamped to 16
    for (int i = 0; i < 16; i++) cfg_wb[i] = 8'(i * 7 + 3);
    start_txn(7'h60, 1'b0, 5'd20, 1'b1, 1'b0, -1, -1); wait_done();
    chk("clamp_windows", 32'(win_idx), 32'd16);
    chk("clamp_last", 32'(obs_lastmask), 32'h0000_8000);
    chk("clamp_status", 32'(status), 32'd0);

    // Reset while a read byte is in flight
    lat_g = 6;
    start_txn(7'h12, 1'b1, 5'd3, 1'b1, 1'b0, -1, -1);
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (exec_byte) begin seen = 1'b1; break; end
      @(negedge clock);
    end
    chk("rst_exec_byte_seen", 32'(seen), 32'd1);
    #2 rst = 1'b1;
    #1 chk_all_zero("midrst");
    repeat (2) @(negedge clock);
    rst = 1'b0;
    started = done_cnt;
    @(negedge clock);
    chk("midrst_req_ready", 32'(req_ready), 32'd1);
    repeat (3) @(negedge clock);
    chk("midrst_no_done", 32'(done_cnt), 32'(started));

    // Normal transaction after the reset
    lat_g = 1; cfg_wb[0] = 8'h5A;
    start_txn(7'h12, 1'b0, 5'd1, 1'b1, 1'b0, -1, -1); wait_done();
    chk("post_word", 32'(obs_word), 32'h0000_0024);
    chk("post_last", 32'(obs_lastmask), 32'h0000_0001);
    chk("post_status", 32'(status), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/i2c_trans_sequencer.md
# i2c_trans_sequencer

Transaction-level sequencer for the I2C master: it accepts one request (7-bit slave address, direction, byte count) and sequences the address stage controller, the data byte stage controller and the stop stage controller through a complete bus transaction. It holds exactly one stage's `exec_*` level at a time, so the stages never contend for the shared 4-tap transfer command bus. It streams write bytes in, read bytes out, and reports a completion status.

## Interface
- `ALEN`, 7: slave address width.
- `MAX_BYTES`, 16: maximum data bytes per transaction.
- `LW`, `$clog2(MAX_BYTES+1)`: width of the length field.

- `clock` in 1: single clock, all logic on the rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `req_vld` / `req_ready` in/out 1: request handshake.
- `req_addr` in ALEN: slave address.
- `req_rd` in 1: 1 = read, 0 = write.
- `req_len` in LW: data byte count. 0 = address-only probe.
- `wr_data` in 8, `wr_data_vld` in 1, `wr_data_ready` out 1: write byte stream.
- `rd_data` out 8, `rd_data_vld` out 1: read byte stream. `rd_data_vld` is a 1-cycle pulse; there is no backpressure.
- `done` out 1: 1-cycle completion pulse.
- `status` out 2: 0 OK, 1 NACK_ADDR, 2 NACK_DATA, 3 TIMEOUT. Valid with `done` and held until the next request.
- `exec_addr` out 1, `addr_word` out ALEN+1 = {req_addr, req_rd} (MSB first), `exec_addr_finish` in 1, `addr_ack` in 1, `addr_timeout` in 1.
- `exec_byte` out 1, `byte_rd` out 1, `byte_last` out 1, `byte_wdata` out 8, `exec_byte_finish` in 1, `byte_rdata` in 8, `byte_ack` in 1, `byte_timeout` in 1.
- `exec_stop` out 1, `exec_stop_finish` in 1.

## Operation
States: IDLE, ADDR, LOAD, BYTE, GAP, STOP, DONE.

- **IDLE**
  - `req_ready`=1.
  - On `req_vld&&req_ready`: capture addr, rd and len; clear `byte_cnt` and `status`; go to ADDR.
- **ADDR**
  - `exec_addr`=1, held until `exec_addr_finish` is sampled 1. `addr_ack` and `addr_timeout` are sampled in that same cycle.
  - Outcome, in priority order:
    - timeout: `status`=TIMEOUT, go to STOP.
    - `!addr_ack`: `status`=NACK_ADDR, go to STOP.
    - `len==0`: go to STOP.
    - write: go to LOAD.
    - read: go to BYTE.
- **LOAD** (write only)
  - `wr_data_ready`=1.
  - On `wr_data_vld`: latch `byte_wdata`, go to BYTE.
  - No timeout; waits indefinitely.
- **BYTE**
  - `exec_byte`=1, with `byte_rd`=rd and `byte_last`=(`byte_cnt`==len-1).
  - The byte stage uses `byte_last` to issue the master NACK on the final read byte.
  - On `exec_byte_finish`, outcome in priority order:
    - `byte_timeout`: TIMEOUT, go to STOP.
    - write with `!byte_ack`: NACK_DATA, go to STOP.
    - read: `rd_data`<=`byte_rdata` and pulse `rd_data_vld`. A timed-out read byte is never emitted.
    - otherwise: `byte_cnt`++. If last, go to STOP; else go to GAP.
- **GAP**
  - One cycle with all `exec_*` at 0, then go to LOAD (write) or BYTE (read).
  - This is required so each stage sees `exec` fall and resets its internal counters.
- **STOP**
  - Always entered on error, so the bus is released.
  - `exec_stop`=1 until `exec_stop_finish`, then go to DONE.
- **DONE**
  - `done`=1 for one cycle, then go to IDLE.

Invariants:
- At most one of `exec_addr`, `exec_byte`, `exec_stop` is high in any cycle.
- Between deassertion of one `exec_*` and assertion of another there is at least one cycle with all low.

## Timing
- All outputs are registered.
- **Reset values**: every output 0, except `addr_word`, `byte_wdata`, `rd_data` and `byte_cnt` cleared to 0 as well; state goes to IDLE.
- **Exec handshake**:
  - `exec_*` rises the cycle after the state is entered.
  - `exec_*` falls the cycle after its `*_finish` is sampled.
  - A `*_finish` received while the matching `exec_*` is low is ignored.
- **Latency**: accept to `exec_addr` high is 1 cycle; `exec_stop_finish` to `done` is 2 cycles.
- **`req_ready`**: low from the accept cycle until the cycle after `done`. Back-to-back requests therefore have at least 1 idle cycle between them.
- **`byte_cnt`** is LW bits wide. A `req_len` > MAX_BYTES is clamped to MAX_BYTES at capture.
- **Reset mid-transaction**: immediate return to IDLE with all `exec_*` low. No STOP is generated, and no `done` is pulsed.

## Structure
- Shared package `i2c_master_pkg`:
  - `seq_state_t` enum.
  - `SEQ_ST_OK`, `SEQ_ST_NACK_ADDR`, `SEQ_ST_NACK_DATA`, `SEQ_ST_TIMEOUT` status constants.
  - The `TRAS_CMD_*` codes, moved here for reuse by all stage controllers.
- Single module, with no sub-module. Target size is roughly 200 lines of RTL.

## Test plan
- **Write 2 bytes**: addr 0x50, len 2, bytes 0xA5, 0x3C, all acks.
  - Required: `addr_word`=0xA0; two `exec_byte` windows with `byte_wdata` 0xA5 then 0x3C; `byte_last` high on the second only; then STOP; `done` with `status`=0.
- **Read 3 bytes**: addr 0x1A, len 3, stage returns 0x11, 0x22, 0x33.
  - Required: `addr_word`=0x35; three `rd_data_vld` pulses carrying those values; `byte_last` high on the third only; `status`=0.
- **Address NACK**: `addr_ack`=0.
  - Required: no `exec_byte`; `exec_stop` asserted; `status`=1.
- **Data NACK on byte 1 of 4**: the write byte with `byte_cnt`=1 gets `byte_ack`=0.
  - Required: STOP immediately after it; `wr_data_ready` never asserts again; `status`=2.
- **Finish and timeout in the same cycle on a read byte**: `exec_byte_finish`=1 and `byte_timeout`=1 together.
  - Required: no `rd_data_vld`; `status`=3.
  - Probe with len 0: ADDR then STOP, `status`=0.
- **Reset mid-BYTE**: assert `rst` while `exec_byte`=1.
  - Required: all outputs are 0 in the same cycle (asynchronous); `req_ready`=1 after release; a new request completes normally.
  - Throughout all tests, an assertion checks exec one-hot and the 1-cycle gap between execs.
